// File: rtl/mod_exp_multi_if.sv
// Host-side handshake and operand bus for the multi-mode modular exponentiator.
// The host drives the master modport; the exponentiator core uses the slave modport.
interface mod_exp_multi_if #(
    parameter int KEY_SIZE = 64,
    parameter int RSA_MOD  = 64,
    parameter int LEN_W    = $clog2(KEY_SIZE) + 1
);
    logic                go;
    logic                abort;
    logic [1:0]          mode;
    logic [LEN_W-1:0]    exp_len;
    logic [RSA_MOD-1:0]  M;
    logic [RSA_MOD-1:0]  N;
    logic [KEY_SIZE-1:0] d;
    logic                busy;
    logic                done;
    logic                err;
    logic [RSA_MOD-1:0]  R;
    logic                bit_strobe;
    logic [LEN_W-1:0]    bit_idx;

    modport master (
        output go, abort, mode, exp_len, M, N, d,
        input  busy, done, err, R, bit_strobe, bit_idx
    );

    modport slave (
        input  go, abort, mode, exp_len, M, N, d,
        output busy, done, err, R, bit_strobe, bit_idx
    );
endinterface

// File: rtl/mod_exp_multi.sv
// Modular exponentiator R = M^d mod N with run-time selectable leaky SQM,
// SQM-always or Montgomery ladder, plus per-bit trace strobes for SPA capture.
//
// state | meaning
// IDLE  | waiting for go; operands latched on acceptance
// BIT   | bit_strobe pulse, exponent bit fetched at bit_idx
// OP_A  | multiply step (acc0*S, or R0*R1 for the ladder)
// OP_B  | squaring step (S*S, or R0^2 / R1^2 for the ladder)
// FIN   | publish result, pulse done
module mod_exp_multi #(
    parameter int KEY_SIZE = 64,
    parameter int RSA_MOD  = 64,
    parameter int LEN_W    = $clog2(KEY_SIZE) + 1
) (
    input  logic             clk,
    input  logic             rst,
    mod_exp_multi_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, BIT, OP_A, OP_B, FIN} state_t;

    state_t state, state_nx;

    logic [RSA_MOD-1:0]  n_q, s_q, acc0_q, acc1_q, dummy_q, r_q;
    logic [KEY_SIZE-1:0] d_q;
    logic [1:0]          mode_q;
    logic [LEN_W-1:0]    len_q, idx_q;
    logic                busy_q, done_q, err_q;

    logic [LEN_W-1:0]     len_clamp;
    logic [RSA_MOD-1:0]   m_red, one_red;
    logic                 bit_b, last_bit;
    logic [RSA_MOD-1:0]   mul_x, mul_y, prod;
    logic [2*RSA_MOD-1:0] prod_wide, n_wide;

    assign len_clamp = (bus.exp_len > LEN_W'(KEY_SIZE)) ? LEN_W'(KEY_SIZE) : bus.exp_len;
    assign m_red     = (bus.N == '0) ? '0 : bus.M % bus.N;
    assign one_red   = (bus.N <= RSA_MOD'(1)) ? '0 : RSA_MOD'(1);

    assign bit_b    = |(d_q & (KEY_SIZE'(1) << idx_q));
    assign last_bit = (mode_q == 2'd2) ? (idx_q == '0) : (idx_q == len_q - LEN_W'(1));

    // Full double-width product, reduced only once against the latched modulus.
    assign prod_wide = {{RSA_MOD{1'b0}}, mul_x} * {{RSA_MOD{1'b0}}, mul_y};
    assign n_wide    = {{RSA_MOD{1'b0}}, n_q};
    assign prod      = (n_q == '0) ? '0 : RSA_MOD'(prod_wide % n_wide);

    always_comb begin
        mul_x = acc0_q;
        mul_y = s_q;
        if (mode_q == 2'd2) begin
            if (state == OP_A) begin
                mul_x = acc0_q;
                mul_y = acc1_q;
            end else begin
                mul_x = bit_b ? acc1_q : acc0_q;
                mul_y = bit_b ? acc1_q : acc0_q;
            end
        end else if (state == OP_B) begin
            mul_x = s_q;
            mul_y = s_q;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.go) state_nx = (bus.N == '0 || len_clamp == '0) ? FIN : BIT;
            BIT:  state_nx = (mode_q == 2'd0 && !bit_b) ? OP_B : OP_A;
            OP_A: state_nx = OP_B;
            OP_B: state_nx = last_bit ? FIN : BIT;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && bus.abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q     <= '0;
            s_q     <= '0;
            acc0_q  <= '0;
            acc1_q  <= '0;
            dummy_q <= '0;
            r_q     <= '0;
            d_q     <= '0;
            mode_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (bus.go) begin
                    n_q     <= bus.N;
                    d_q     <= bus.d;
                    mode_q  <= (bus.mode == 2'd3) ? 2'd2 : bus.mode;
                    len_q   <= len_clamp;
                    s_q     <= m_red;
                    acc0_q  <= one_red;
                    acc1_q  <= m_red;
                    dummy_q <= '0;
                    idx_q   <= (bus.mode[1] && len_clamp != '0) ? len_clamp - LEN_W'(1) : '0;
                    busy_q  <= 1'b1;
                    err_q   <= 1'b0;
                end
                BIT: ;
                OP_A: begin
                    if (mode_q == 2'd2) begin
                        if (bit_b) acc0_q <= prod;
                        else       acc1_q <= prod;
                    end else if (mode_q == 2'd1 && !bit_b) begin
                        dummy_q <= prod;
                    end else begin
                        acc0_q <= prod;
                    end
                end
                OP_B: begin
                    if (mode_q == 2'd2) begin
                        if (bit_b) acc1_q <= prod;
                        else       acc0_q <= prod;
                    end else begin
                        s_q <= prod;
                    end
                    if (!last_bit)
                        idx_q <= (mode_q == 2'd2) ? idx_q - LEN_W'(1) : idx_q + LEN_W'(1);
                end
                FIN: if (!bus.abort) begin
                    r_q    <= (n_q == '0) ? '0 : acc0_q;
                    err_q  <= (n_q == '0);
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
            if (state != IDLE && bus.abort) busy_q <= 1'b0;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.R          = r_q;
    assign bus.bit_strobe = (state == BIT);
    assign bus.bit_idx    = idx_q;
endmodule
